// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier: FSM encoding,
// default operand width and the iteration-counter width derivation.
package booth_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 16;

  // One extra bit over clog2(WIDTH/2) so the counter never wraps before the last iteration.
  function automatic int cnt_width(input int w);
    return $clog2(w / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth encoder cell: maps triplet (c,a,b) = (y[i+1], y[i], y[i-1])
// to single (s), double (d) and negate (n) select lines.
module booth_enc (
  input  logic c,
  input  logic a,
  input  logic b,
  output logic s,
  output logic d,
  output logic n
);

  // Combinational Booth recoding.
  always_comb begin
    s = a ^ b;
    d = (c & ~a & ~b) | (~c & a & b);
    n = c;
  end

endmodule

// File: rtl/booth_seq_mult_pp_sel.sv
// Partial-product selector: picks 0, +/-M or +/-2M from the Booth select lines,
// sign-extended to WIDTH+2 bits.
module booth_pp_sel #(
  parameter int WIDTH = 16
) (
  input  logic             s,
  input  logic             d,
  input  logic             n,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] mag_s;

  // Magnitude select, then conditional two's-complement negate; a zero
  // magnitude negates to zero, so triplet 111 cannot yield a stray +1.
  always_comb begin
    mag_s = {(WIDTH+2){1'b0}};
    if (s) begin
      mag_s = {{2{m[WIDTH-1]}}, m};
    end else if (d) begin
      mag_s = {m[WIDTH-1], m, 1'b0};
    end else begin
      mag_s = {(WIDTH+2){1'b0}};
    end
    if (n) begin
      pp = ~mag_s + {{(WIDTH+1){1'b0}}, 1'b1};
    end else begin
      pp = mag_s;
    end
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier behind valid/ready handshakes:
// one Booth digit per cycle, WIDTH/2 iterations per product.
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / 2 - 1);

  state_t                 state_r, next_state_s;
  logic [WIDTH-1:0]       m_r, q_r;
  logic                   prior_r;
  logic signed [WIDTH+1:0] acc_r;
  logic [CW-1:0]          cnt_r;
  logic [2*WIDTH-1:0]     product_r;
  logic                   in_ready_r, out_valid_r;

  logic                   sel_single_s, sel_double_s, sel_neg_s;
  logic signed [WIDTH+1:0] pp_s, sum_s;
  logic signed [2*WIDTH+2:0] shift_s;
  logic                   last_iter_s;

  booth_enc u_enc (
    .c (q_r[1]),
    .a (q_r[0]),
    .b (prior_r),
    .s (sel_single_s),
    .d (sel_double_s),
    .n (sel_neg_s)
  );

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .s  (sel_single_s),
    .d  (sel_double_s),
    .n  (sel_neg_s),
    .m  (m_r),
    .pp (pp_s)
  );

  // Accumulate and arithmetic-shift the combined {acc, Q, prior} register by one digit.
  always_comb begin
    sum_s       = acc_r + pp_s;
    shift_s     = $signed({sum_s, q_r, prior_r}) >>> 2;
    last_iter_s = (cnt_r == LAST_CNT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = RUN;
        else          next_state_s = IDLE;
      end
      RUN: begin
        if (last_iter_s) next_state_s = DONE;
        else             next_state_s = RUN;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand load, iteration datapath and product capture on the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r       <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      prior_r   <= 1'b0;
      acc_r     <= {(WIDTH+2){1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            m_r     <= mcand;
            q_r     <= mplier;
            prior_r <= 1'b0;
            acc_r   <= {(WIDTH+2){1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r   <= shift_s[2*WIDTH+2:WIDTH+1];
          q_r     <= shift_s[WIDTH:1];
          prior_r <= shift_s[0];
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_iter_s) begin
            product_r <= {shift_s[2*WIDTH:WIDTH+1], shift_s[WIDTH:1]};
          end
        end
        default: begin
          product_r <= product_r;
        end
      endcase
    end
  end

  // Handshake flags registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: accepted operands push a reference product,
// a monitor pops and compares on every output handshake and checks latency.
module tb_booth_seq_mult;

  localparam int W = 16;
  localparam int LAT = W / 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;

  logic [2*W-1:0] exp_q[$];
  int             acc_cyc_q[$];

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // out_ready driver: random stalls or a fixed level
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else            out_ready = fixed_ready;
    end
  end

  // Monitor: push on accept, check latency, stall stability and product on handshake
  initial begin
    bit             prev_valid;
    bit             prev_ready;
    logic [2*W-1:0] prev_prod;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_prod  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_mul(mcand, mplier));
          acc_cyc_q.push_back(cyc + 1);
        end
        if (out_valid && !prev_valid) begin
          if (acc_cyc_q.size() > 0) chk("latency", 64'(cyc - acc_cyc_q[0]), 64'(LAT));
          else                      fail("spurious_out_valid");
        end
        if (out_valid && prev_valid && !prev_ready) chk("stall_hold", 64'(product), 64'(prev_prod));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_product");
          end else begin
            chk("product", 64'(product), 64'(exp_q.pop_front()));
            if (acc_cyc_q.size() > 0) void'(acc_cyc_q.pop_front());
          end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_prod  = product;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    mcand    = a;
    mplier   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("out_valid_timeout");
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic product, latency and in_ready return
    issue(16'd3, 16'd5);
    wait_valid();
    chk("t1_product", 64'(product), 64'h0000_000F);
    @(negedge clk);
    chk("t1_out_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_in_ready_back", 64'(in_ready), 64'd1);

    // 2 and 3: signed cases and extremes
    issue(16'hFFF9, 16'd6);   drain();
    issue(16'd1234, 16'hFFFF); drain();
    issue(16'h8000, 16'h8000); drain();
    issue(16'h7FFF, 16'h7FFF); drain();
    issue(16'h8000, 16'h7FFF); drain();
    chk("t2_ref_neg42", 64'(ref_mul(16'hFFF9, 16'd6)), 64'hFFFF_FFD6);

    // 4: backpressure with a pending in_valid
    fixed_ready = 1'b0;
    @(posedge clk);
    issue(16'd3, 16'd7);
    wait_valid();
    @(posedge clk);
    #1;
    mcand    = 16'h0011;
    mplier   = 16'h0002;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_held", 64'(out_valid), 64'd1);
      chk("t4_in_ready_low", 64'(in_ready), 64'd0);
      chk("t4_product_stable", 64'(product), 64'd21);
    end
    fixed_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail("t4_reaccept_timeout");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // 5: asynchronous reset during iteration 3
    issue(16'h0055, 16'h0AAA);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5_no_out_valid", 64'(out_valid), 64'd0);
    end
    issue(16'd0, 16'h1234);
    wait_valid();
    chk("t5_zero_product", 64'(product), 64'd0);
    drain();

    // 6: randomized sweep with random stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      issue(W'($urandom), W'($urandom));
    end
    drain();
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Iterative signed radix-4 Booth multiplier. It is the consumer stage of the BOOTH_ENC encoder cell. Each cycle it forms one multiplier-bit triplet, feeds it to a BOOTH_ENC instance, selects 0/±M/±2M from the encoder outputs s, d and n, and accumulates the result with an arithmetic shift. It sits in the datapath as a low-area multiply unit behind a valid/ready handshake.

Parameters:
WIDTH, 16, operand width in bits; must be even and ≥4. Product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
mcand  input  WIDTH  multiplicand M, two's complement
mplier  input  WIDTH  multiplier Y, two's complement
out_valid  output  1  product available
out_ready  input  1  consumer takes product
product  output  2*WIDTH  signed M*Y, two's complement

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, in_ready=1, out_valid=0, product=0.
  - All internal registers (accumulator, shift register, counter, M, prior bit) cleared.
- Reset mid-operation aborts the operation. No output is produced and the result is lost.
- States are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, load the registers below and go to RUN.
    - M ← mcand.
    - Q ← mplier.
    - prior bit y[-1] ← 0.
    - acc (WIDTH+2 bits, signed) ← 0.
    - cnt ← 0.
  - RUN: in_ready=0, out_valid=0. Each edge performs one iteration.
    - Triplet to BOOTH_ENC: c=Q[1], a=Q[0], b=prior.
    - Partial-product select:
      - pp = 0 when s=0 and d=0, regardless of n. Triplet 111 must not produce −0 or a stray +1.
      - pp = M sign-extended to WIDTH+2 when s=1.
      - pp = 2M sign-extended to WIDTH+2 when d=1.
      - n=1 negates pp (two's complement).
    - Update: sum = acc + pp, both WIDTH+2 signed. Then {acc,Q,prior} ← arithmetic right shift by 2 of {sum,Q,prior}. New prior = old Q[1].
    - cnt increments each iteration. After iteration WIDTH/2, go to DONE.
  - DONE: out_valid=1, product = {acc[WIDTH-1:0], Q}, sign-correct.
    - product holds stable while out_valid=1 and out_ready=0.
    - On out_ready, go to IDLE. in_ready is 0 during that DONE cycle, so there is no same-cycle reissue.
- Latency: out_valid rises exactly WIDTH/2 cycles after the accepting edge (8 for WIDTH=16). Throughput is one product per WIDTH/2+2 cycles at best.
- Arithmetic:
  - WIDTH+2 accumulator bits suffice for ±2M with M=−2^(WIDTH−1).
  - Overflow is impossible. The full 2*WIDTH result is exact for all input pairs, including (−2^(W−1))².
- in_valid while not in IDLE is ignored. The operands are not captured.
- out_ready in IDLE or RUN is ignored.
- product is held at its last value outside DONE. It is 0 after reset.

Decomposition:
- booth_defs.vh holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - the WIDTH default.
  - the counter-width derivation (clog2(WIDTH/2)+1).
- One sub-module, booth_pp_sel, purely combinational:
  - inputs: s, d, n, M[WIDTH-1:0].
  - output: pp[WIDTH+1:0].
  - implements the zero/±M/±2M selection with the 111→0 rule.
- The top instantiates BOOTH_ENC, booth_pp_sel, the accumulator/shift datapath and the FSM.

Test Plan (WIDTH=16):
1. mcand=3, mplier=5, out_ready=1 -> out_valid exactly 8 cycles after accept; product=0x0000000F; in_ready returns 1 one cycle after DONE.
2. mcand=−7 (0xFFF9), mplier=6 -> product=0xFFFFFFD6 (−42). Then mcand=1234, mplier=0xFFFF -> product=0xFFFFFB2E. This exercises triplet 111 giving pp=0.
3. Extremes -> product as listed:
   - mcand=mplier=0x8000 -> 0x40000000.
   - 0x7FFF×0x7FFF -> 0x3FFF0001.
   - 0x8000×0x7FFF -> 0xC0008000.
4. Backpressure: out_ready=0 for 5 cycles after DONE -> out_valid held, product stable, in_ready=0, new in_valid ignored. out_ready=1 -> accepted, next operands loaded afterwards.
5. Reset mid-RUN: assert rst_n=0 at iteration 3 asynchronously -> outputs immediately in_ready=1, out_valid=0, product=0. No out_valid appears afterward. The next operation 0×0x1234 -> product=0.
6. Randomised sweep of 1000 operand pairs with random out_ready stalls -> product equals the signed reference model. Latency is always 8.
